id_ex_reg: RTL and testbench
============================

// Module: id_ex_reg
// PURPOSE
//  ID/EX pipeline register of the 5-stage RV32I core. Captures decode-stage (_de) operands, register
//  indices and control bits each cycle and presents them to execute (_ex). Consumes the HDU `clr`
//  (load-use bubble) and the branch `flush`. Produces rd_ex/DMrd_ex, which feed back into the HDU.
//  Keeps saturating bubble counters for performance analysis.
// PARAMETERS
//  XLEN   32  datapath width (pc, operands, immediate)
//  CNT_W  16  width of each bubble counter
// PORTS
//  clk               in   1      rising-edge clock
//  rst               in   1      synchronous reset, active-high
//  en                in   1      1 = load, 0 = hold all fields (global stall)
//  clr               in   1      HDU load-use bubble request
//  flush             in   1      taken-branch/jump squash request
//  valid_de          in   1      decode slot holds a real instruction
//  pc_de, pcplus4_de in   XLEN   PC and PC+4 of the decoded instruction
//  rs1data_de, rs2data_de in XLEN register-file read data
//  imm_de            in   XLEN   sign-extended immediate
//  rs1_de, rs2_de, rd_de in 5    register indices
//  ctrl_de           in   ctrl_t RUWr, DMWr, DMrd, RUDataWrSrc[1:0], ALUASrc, ALUBSrc, ALUOp[3:0], BrOp[4:0], DMCtrl[2:0]
//  <each field>_ex   out  same   registered copy of the matching _de input (incl. valid_ex, ctrl_ex)
//  DMrd_ex           out  1      alias of ctrl_ex.DMrd, wired to the HDU
//  lu_bubbles        out  CNT_W  count of bubbles inserted by clr
//  fl_bubbles        out  CNT_W  count of bubbles inserted by flush
// BEHAVIOUR
//  - Latency 1 cycle. All outputs are registered. No combinational path from input to output.
//  - Per-edge priority: rst > flush > clr > !en (hold) > load.
//  - rst: every _ex output = 0 (ctrl_ex = CTRL_NOP, valid_ex = 0, rd_ex = 0); both counters = 0.
//  - Bubble (flush or clr): every _ex field = 0, ctrl_ex = CTRL_NOP (RUWr = DMWr = DMrd = 0,
//    BrOp = BR_NONE), valid_ex = 0. rd_ex = 0 so the HDU cannot match a bubble (x0 never hazards).
//  - A bubble is inserted even when en = 0. clr must break a stall; the HDU stalls IF/ID and clears ID/EX
//    in the same cycle.
//  - Hold (en = 0, no bubble): every _ex field keeps its value. Counters are unchanged.
//  - Load: every _ex field <= its _de value, including valid_de = 0 slots.
//  - Counters: fl_bubbles += 1 on each flush edge. lu_bubbles += 1 on each clr edge only when flush = 0,
//    so a simultaneous event is charged to flush alone.
//  - Counters saturate at 2^CNT_W-1 and never wrap. Only rst returns them to 0.
//  - rst asserted mid-stream discards the captured instruction. The first edge after rst deasserts
//    behaves as a normal load/hold/bubble.
//  - valid_de = 0 with no bubble still loads all fields. No counter increments (not a bubble).
// STRUCTURE
//  - core_pkg: XLEN default, ctrl_t packed struct, CTRL_NOP constant, BR_NONE / ALU_ADD encodings.
//    Shared with decode, HDU, forwarding and EX.
//  - One sub-module: sat_counter #(W) (inc, clk, rst -> q), instantiated twice for the bubble counters.
//  - Remaining logic is a single always_ff block with the priority chain above.
// TESTING
//  1. rst = 1 for 2 cycles, all inputs random -> every _ex = 0, ctrl_ex == CTRL_NOP, both counters 0.
//  2. Load rd_de = 2, DMrd = 1, rs1data_de = 32'hDEAD_BEEF, en = 1 -> one edge later rd_ex = 2,
//     DMrd_ex = 1, rs1data_ex = DEADBEEF, valid_ex = 1.
//  3. Load-use: lw x2 in EX, add uses x2 -> HDU clr = 1 with en = 0 -> next edge rd_ex = 0, DMrd_ex = 0,
//     valid_ex = 0, lu_bubbles = 1. Following edge loads the held add (rs2_ex = 2).
//  4. Stall hold: en = 0 for 3 cycles with changing _de inputs -> _ex unchanged, counters unchanged.
//  5. clr = 1 and flush = 1 on the same edge -> bubble. fl_bubbles += 1, lu_bubbles unchanged.
//  6. CNT_W = 4, 17 consecutive flushes -> fl_bubbles stops at 15. rst mid-run -> 0 on the next edge.

Source files
------------

// File: rtl/core_pkg.sv
// Shared RV32I core types: datapath width, decode control bundle and its NOP encoding.
package core_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [4:0] BR_NONE = 5'd0;
  localparam logic [3:0] ALU_ADD = 4'd0;

  typedef struct packed {
    logic       RUWr;
    logic       DMWr;
    logic       DMrd;
    logic [1:0] RUDataWrSrc;
    logic       ALUASrc;
    logic       ALUBSrc;
    logic [3:0] ALUOp;
    logic [4:0] BrOp;
    logic [2:0] DMCtrl;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '{
    RUWr:        1'b0,
    DMWr:        1'b0,
    DMrd:        1'b0,
    RUDataWrSrc: 2'd0,
    ALUASrc:     1'b0,
    ALUBSrc:     1'b0,
    ALUOp:       ALU_ADD,
    BrOp:        BR_NONE,
    DMCtrl:      3'd0
  };

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping; only rst clears it.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (inc && (q_q != {W{1'b1}})) q_d = q_q + W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) q_q <= '0;
    else     q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register: load/hold/bubble with rst > flush > clr > hold > load,
// plus saturating counters of bubbles caused by load-use clears and branch flushes.
module id_ex_reg #(
  parameter int unsigned XLEN  = core_pkg::XLEN,
  parameter int unsigned CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  clr,
  input  logic                  flush,
  input  logic                  valid_de,
  input  logic [XLEN-1:0]       pc_de,
  input  logic [XLEN-1:0]       pcplus4_de,
  input  logic [XLEN-1:0]       rs1data_de,
  input  logic [XLEN-1:0]       rs2data_de,
  input  logic [XLEN-1:0]       imm_de,
  input  logic [4:0]            rs1_de,
  input  logic [4:0]            rs2_de,
  input  logic [4:0]            rd_de,
  input  core_pkg::ctrl_t       ctrl_de,
  output logic                  valid_ex,
  output logic [XLEN-1:0]       pc_ex,
  output logic [XLEN-1:0]       pcplus4_ex,
  output logic [XLEN-1:0]       rs1data_ex,
  output logic [XLEN-1:0]       rs2data_ex,
  output logic [XLEN-1:0]       imm_ex,
  output logic [4:0]            rs1_ex,
  output logic [4:0]            rs2_ex,
  output logic [4:0]            rd_ex,
  output core_pkg::ctrl_t       ctrl_ex,
  output logic                  DMrd_ex,
  output logic [CNT_W-1:0]      lu_bubbles,
  output logic [CNT_W-1:0]      fl_bubbles
);

  import core_pkg::*;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pcplus4;
    logic [XLEN-1:0] rs1data;
    logic [XLEN-1:0] rs2data;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    ctrl_t           ctrl;
  } stage_t;

  // rd = 0 in a bubble keeps the HDU from matching it (x0 never hazards).
  localparam stage_t BUBBLE = '{
    valid:   1'b0,
    pc:      '0,
    pcplus4: '0,
    rs1data: '0,
    rs2data: '0,
    imm:     '0,
    rs1:     5'd0,
    rs2:     5'd0,
    rd:      5'd0,
    ctrl:    CTRL_NOP
  };

  stage_t stage_q;
  stage_t stage_d;
  logic   lu_inc;
  logic   fl_inc;

  always_comb begin
    stage_d = stage_q;
    if (flush || clr) begin
      stage_d = BUBBLE;
    end else if (en) begin
      stage_d.valid   = valid_de;
      stage_d.pc      = pc_de;
      stage_d.pcplus4 = pcplus4_de;
      stage_d.rs1data = rs1data_de;
      stage_d.rs2data = rs2data_de;
      stage_d.imm     = imm_de;
      stage_d.rs1     = rs1_de;
      stage_d.rs2     = rs2_de;
      stage_d.rd      = rd_de;
      stage_d.ctrl    = ctrl_de;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) stage_q <= BUBBLE;
    else     stage_q <= stage_d;
  end

  // A simultaneous clr+flush is charged to flush only.
  assign fl_inc = flush;
  assign lu_inc = clr & ~flush;

  sat_counter #(.W(CNT_W)) u_lu_cnt (
    .clk (clk),
    .rst (rst),
    .inc (lu_inc),
    .q   (lu_bubbles)
  );

  sat_counter #(.W(CNT_W)) u_fl_cnt (
    .clk (clk),
    .rst (rst),
    .inc (fl_inc),
    .q   (fl_bubbles)
  );

  assign valid_ex   = stage_q.valid;
  assign pc_ex      = stage_q.pc;
  assign pcplus4_ex = stage_q.pcplus4;
  assign rs1data_ex = stage_q.rs1data;
  assign rs2data_ex = stage_q.rs2data;
  assign imm_ex     = stage_q.imm;
  assign rs1_ex     = stage_q.rs1;
  assign rs2_ex     = stage_q.rs2;
  assign rd_ex      = stage_q.rd;
  assign ctrl_ex    = stage_q.ctrl;
  assign DMrd_ex    = stage_q.ctrl.DMrd;

endmodule

// File: tb/tb_id_ex_reg.sv
// Bench for id_ex_reg (4-bit bubble counters): reference model feeds a scoreboard queue each edge.
module tb_id_ex_reg;
  import core_pkg::*;

  localparam int unsigned CW = $bits(ctrl_t);

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] pcplus4;
    logic [31:0] rs1data;
    logic [31:0] rs2data;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    ctrl_t       ctrl;
    logic        dmrd;
    logic [3:0]  lu;
    logic [3:0]  fl;
  } obs_t;

  logic        clk = 1'b0;
  logic        rst, en, clr, flush, valid_de;
  logic [31:0] pc_de, pcplus4_de, rs1data_de, rs2data_de, imm_de;
  logic [4:0]  rs1_de, rs2_de, rd_de;
  ctrl_t       ctrl_de;
  logic        valid_ex, DMrd_ex;
  logic [31:0] pc_ex, pcplus4_ex, rs1data_ex, rs2data_ex, imm_ex;
  logic [4:0]  rs1_ex, rs2_ex, rd_ex;
  ctrl_t       ctrl_ex;
  logic [3:0]  lu_bubbles, fl_bubbles;

  int   checks   = 0;
  int   failures = 0;
  obs_t model;
  obs_t sb[$];

  always #5 clk = ~clk;

  id_ex_reg #(.XLEN(32), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .flush(flush), .valid_de(valid_de),
    .pc_de(pc_de), .pcplus4_de(pcplus4_de), .rs1data_de(rs1data_de), .rs2data_de(rs2data_de),
    .imm_de(imm_de), .rs1_de(rs1_de), .rs2_de(rs2_de), .rd_de(rd_de), .ctrl_de(ctrl_de),
    .valid_ex(valid_ex), .pc_ex(pc_ex), .pcplus4_ex(pcplus4_ex), .rs1data_ex(rs1data_ex),
    .rs2data_ex(rs2data_ex), .imm_ex(imm_ex), .rs1_ex(rs1_ex), .rs2_ex(rs2_ex), .rd_ex(rd_ex),
    .ctrl_ex(ctrl_ex), .DMrd_ex(DMrd_ex), .lu_bubbles(lu_bubbles), .fl_bubbles(fl_bubbles)
  );

  function automatic logic [3:0] sat_inc(input logic [3:0] x);
    return (x == 4'hF) ? x : x + 4'd1;
  endfunction

  task automatic rand_de();
    logic [31:0] r;
    r = $urandom;
    valid_de   = r[0];
    rs1_de     = r[5:1];
    rs2_de     = r[10:6];
    rd_de      = r[15:11];
    r = $urandom;
    ctrl_de    = r[CW-1:0];
    pc_de      = $urandom;
    pcplus4_de = pc_de + 32'd4;
    rs1data_de = $urandom;
    rs2data_de = $urandom;
    imm_de     = $urandom;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model of one edge; expectation is queued, the edge taken, then the DUT compared.
  task automatic step(input string tag);
    obs_t e, o;
    e = model;
    if (rst) begin
      e = '0;
      e.ctrl = CTRL_NOP;
    end else begin
      if (flush || clr) begin
        e.valid = 1'b0; e.pc = '0; e.pcplus4 = '0; e.rs1data = '0; e.rs2data = '0;
        e.imm = '0; e.rs1 = '0; e.rs2 = '0; e.rd = '0; e.ctrl = CTRL_NOP;
      end else if (en) begin
        e.valid = valid_de; e.pc = pc_de; e.pcplus4 = pcplus4_de; e.rs1data = rs1data_de;
        e.rs2data = rs2data_de; e.imm = imm_de; e.rs1 = rs1_de; e.rs2 = rs2_de; e.rd = rd_de;
        e.ctrl = ctrl_de;
      end
      if (flush)       e.fl = sat_inc(model.fl);
      else if (clr)    e.lu = sat_inc(model.lu);
    end
    e.dmrd = e.ctrl.DMrd;
    model = e;
    sb.push_back(e);
    @(posedge clk);
    #1;
    o = '{valid: valid_ex, pc: pc_ex, pcplus4: pcplus4_ex, rs1data: rs1data_ex,
          rs2data: rs2data_ex, imm: imm_ex, rs1: rs1_ex, rs2: rs2_ex, rd: rd_ex,
          ctrl: ctrl_ex, dmrd: DMrd_ex, lu: lu_bubbles, fl: fl_bubbles};
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $error("FAIL %s: scoreboard empty", tag);
    end else begin
      e = sb.pop_front();
      assert (o === e) else begin
        failures++;
        $error("FAIL %s: observed=%h expected=%h", tag, o, e);
      end
    end
  endtask

  initial begin
    model = '0;
    model.ctrl = CTRL_NOP;
    rand_de();
    rst = 1'b1; en = $urandom_range(1); clr = $urandom_range(1); flush = $urandom_range(1);

    // Reset with random inputs
    step("reset0");
    rand_de(); en = $urandom_range(1); clr = $urandom_range(1); flush = $urandom_range(1);
    step("reset1");
    chk("reset_rd", 64'(rd_ex), 64'd0);
    chk("reset_ctrl", 64'(ctrl_ex), 64'(CTRL_NOP));
    chk("reset_cnt", 64'({lu_bubbles, fl_bubbles}), 64'd0);

    // Load a lw x2
    rst = 1'b0; clr = 1'b0; flush = 1'b0; en = 1'b1;
    rand_de();
    valid_de = 1'b1; rd_de = 5'd2; ctrl_de = CTRL_NOP; ctrl_de.DMrd = 1'b1; ctrl_de.RUWr = 1'b1;
    rs1data_de = 32'hDEAD_BEEF;
    step("load_lw");
    chk("lw_rd", 64'(rd_ex), 64'd2);
    chk("lw_dmrd", 64'(DMrd_ex), 64'd1);
    chk("lw_rs1data", 64'(rs1data_ex), 64'hDEAD_BEEF);
    chk("lw_valid", 64'(valid_ex), 64'd1);

    // Load-use: add x3 uses x2; HDU stalls and clears
    rand_de();
    valid_de = 1'b1; rs2_de = 5'd2; rd_de = 5'd3; ctrl_de = CTRL_NOP; ctrl_de.RUWr = 1'b1;
    clr = 1'b1; en = 1'b0;
    step("lu_bubble");
    chk("lu_rd", 64'(rd_ex), 64'd0);
    chk("lu_dmrd", 64'(DMrd_ex), 64'd0);
    chk("lu_valid", 64'(valid_ex), 64'd0);
    chk("lu_cnt", 64'(lu_bubbles), 64'd1);
    clr = 1'b0; en = 1'b1;
    step("lu_reload");
    chk("add_rs2", 64'(rs2_ex), 64'd2);

    // Stall hold with changing inputs
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rand_de();
      step("hold");
    end
    chk("hold_rs2", 64'(rs2_ex), 64'd2);
    chk("hold_cnt", 64'({lu_bubbles, fl_bubbles}), 64'h10);

    // valid_de = 0 still loads, no counter change
    en = 1'b1; rand_de(); valid_de = 1'b0; pc_de = 32'h0000_1230;
    step("invalid_load");
    chk("inv_pc", 64'(pc_ex), 64'h1230);
    chk("inv_cnt", 64'({lu_bubbles, fl_bubbles}), 64'h10);

    // clr and flush together
    rand_de(); clr = 1'b1; flush = 1'b1;
    step("clr_flush");
    chk("both_cnt", 64'({lu_bubbles, fl_bubbles}), 64'h11);

    // Flush saturation
    for (int i = 0; i < 17; i++) begin
      rand_de(); en = $urandom_range(1); clr = $urandom_range(1); flush = 1'b1;
      step("flush_run");
    end
    chk("fl_sat", 64'(fl_bubbles), 64'hF);

    // rst mid-run
    rand_de(); rst = 1'b1; flush = 1'b1; clr = 1'b1;
    step("mid_rst");
    chk("mid_rst_cnt", 64'({lu_bubbles, fl_bubbles}), 64'd0);

    // Random mixed traffic
    for (int i = 0; i < 60; i++) begin
      rand_de();
      rst   = ($urandom_range(19) == 0);
      flush = ($urandom_range(3) == 0);
      clr   = ($urandom_range(2) == 0);
      en    = ($urandom_range(3) != 0);
      step("random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
